prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Serial PRBS checker: receive end of the LFSR bit-stream generator.
//  - Self-synchronises a local LFSR to the incoming bit stream.
//  - Declares lock after a run of correct predictions, then counts bit errors.
//  - Sits after a loopback, pin or link under test; reports status to LEDs/UART.
// PARAMETERS
//  NUM_BITS    5      LFSR length; must match the generator
//  TAPS        5'h1B  feedback tap mask; must match the generator
//  LOCK_COUNT  16     consecutive correct predictions required to declare lock
//  LOSS_COUNT  4      errors without an intervening LOCK_COUNT-good run that drop lock
//  CNT_W       16     width of the error counter (and of the optional bit counter)
// PORTS
//  i_clk      in   1      clock; all logic on rising edge
//  i_rst_n    in   1      asynchronous reset, active low
//  i_bit      in   1      received serial bit
//  i_valid    in   1      i_bit is sampled only when high; tie high for a free-running generator
//  i_clr_cnt  in   1      synchronous clear of the error (and bit) counters
//  o_locked   out  1      high while in state LOCKED
//  o_err      out  1      one-cycle pulse per mismatch while LOCKED
//  o_err_cnt  out  CNT_W  saturating error count
//  o_bit_cnt  out  CNT_W  saturating count of bits checked while LOCKED (only with PRBS_CHK_BITCNT_EN)
// BEHAVIOUR
//  - Local register r[NUM_BITS-1:0]. On every valid bit it shifts: r <= {r[NUM_BITS-2:0], x}.
//  - Prediction: pred = XOR over i of (r[i] & TAPS[i]); this is the same feedback as the generator.
//  - Async reset clears r, all counters and all outputs to 0, and sets state SEEK.
//  - A cycle with i_valid=0 changes no state, no counter and no output; o_err is 0 in that cycle.
//  - SEEK:
//    - x = i_bit; fill counter counts valid bits.
//    - After NUM_BITS valid bits go to VERIFY, with the match counter at 0.
//  - VERIFY:
//    - x = i_bit. If i_bit==pred, match++.
//    - If i_bit!=pred, or r==0, go to SEEK and restart the fill count at 0.
//    - The r==0 rule stops a stuck-at-0 line from ever locking.
//    - When match reaches LOCK_COUNT, go to LOCKED. o_locked=1 from the edge that samples that bit.
//    - Lock latency from a clean stream: exactly NUM_BITS+LOCK_COUNT valid bits.
//  - LOCKED:
//    - x = pred (free-run), so a single line error does not propagate.
//    - On mismatch:
//      - o_err=1 on the next cycle (registered).
//      - o_err_cnt+1, saturating at 2^CNT_W-1.
//      - loss counter +1, and the good-run counter is cleared.
//    - On match: good-run +1. At LOCK_COUNT the loss counter and good-run counter clear.
//    - When the loss counter reaches LOSS_COUNT: go to SEEK with fill count 0, and o_locked=0 on the same edge.
//    - o_err_cnt is kept when lock is lost.
//  - i_clr_cnt: clears o_err_cnt (and o_bit_cnt) at the next edge.
//    - A clear in the same cycle as an error wins: the count is 0, but o_err still pulses.
//    - The clear does not affect state or lock.
//  - All outputs are registered. There is no combinational path from input to output.
// CONFIGURATION
//  - PRBS_CHK_BITCNT_EN defined:
//    - o_bit_cnt port exists.
//    - It increments on every valid bit in LOCKED, saturates, and is cleared by reset and by i_clr_cnt.
//    - With o_err_cnt it gives the bit error rate.
//  - Not defined: o_bit_cnt port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//  - prbs_pkg:
//    - state encoding SEEK/VERIFY/LOCKED.
//    - default NUM_BITS/TAPS/SEED constants, shared with the generator so both ends match.
//  - Sub-module prbs_feedback: combinational tap-parity tree (params NUM_BITS, TAPS; in r, out pred).
//    - Reusable by the generator.
//  - Top: FSM, fill/match/loss counters, error and bit counters.
// TESTING (NUM_BITS=5, TAPS=5'h1B, generator SEED=1, i_valid=1 unless stated)
//  1. Generator wired to i_bit after reset -> o_locked rises at valid bit 21; o_err_cnt=0 after 1000 bits.
//  2. Locked, invert one bit -> one o_err pulse, o_err_cnt=1, o_locked stays 1, no further errors.
//  3. Locked, invert 4 bits within 10 bits -> o_locked falls at the 4th error; relocks 21 clean bits later;
//     o_err_cnt=4.
//  4. i_bit held 0 for 200 cycles -> o_locked never rises; o_err never pulses.
//  5. i_valid toggled every other cycle, generator advanced only on valid -> lock at 21st valid bit (cycle ~42);
//     invalid cycles change nothing.
//  6. Async i_rst_n low mid-lock with no clock edge -> o_locked=0 and o_err_cnt=0 immediately;
//     i_clr_cnt in the same cycle as an error -> o_err=1, o_err_cnt=0.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the PRBS generator and checker.
//   - chk_state_t : checker state encoding (SEEK / VERIFY / LOCKED)
//   - PRBS_NUM_BITS, PRBS_TAPS, PRBS_SEED : default LFSR setup. Both ends of a
//     link take their defaults from here so they agree on the sequence.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int         PRBS_NUM_BITS = 5;
    localparam logic [4:0] PRBS_TAPS     = 5'h1B;
    localparam logic [4:0] PRBS_SEED     = 5'h01;

endpackage

// File: rtl/prbs_feedback.sv
// prbs_feedback: combinational LFSR feedback (tap-parity tree).
// The generator uses the same block, so it computes the same feedback.
//   r    in  NUM_BITS  current LFSR contents
//   pred out 1         XOR of the register bits selected by TAPS
module prbs_feedback
    import prbs_pkg::*;
#(
    parameter int                  NUM_BITS = PRBS_NUM_BITS,
    parameter logic [NUM_BITS-1:0] TAPS     = PRBS_TAPS
) (
    input  logic [NUM_BITS-1:0] r,
    output logic                pred
);

    assign pred = ^(r & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker. It locks a local LFSR onto the incoming
// stream, declares lock after LOCK_COUNT good predictions in a row, then counts
// bit errors.
// Optional feature macro: PRBS_CHK_BITCNT_EN adds o_bit_cnt, a count of the
// bits checked while locked.
// Ports:
//   i_clk, i_rst_n  clock (rising edge) and asynchronous active-low reset
//   i_bit, i_valid  received serial bit and its qualifier
//   i_clr_cnt       synchronous clear of the error and bit counters
//   o_locked        high while locked
//   o_err           one-cycle pulse for each mismatch while locked
//   o_err_cnt       saturating error count
//   o_bit_cnt       saturating count of bits checked while locked (optional)
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int                  NUM_BITS   = PRBS_NUM_BITS,
    parameter logic [NUM_BITS-1:0] TAPS       = PRBS_TAPS,
    parameter int                  LOCK_COUNT = 16,
    parameter int                  LOSS_COUNT = 4,
    parameter int                  CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit,
    input  logic             i_valid,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] o_bit_cnt
`endif
);

    localparam int FILL_W  = $clog2(NUM_BITS + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(NUM_BITS - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

    chk_state_t          state;
    logic [NUM_BITS-1:0] r;
    logic [FILL_W-1:0]   fill_cnt;
    logic [MATCH_W-1:0]  match_cnt;  // consecutive good predictions in VERIFY
    logic [MATCH_W-1:0]  good_cnt;   // good-run length in LOCKED
    logic [LOSS_W-1:0]   loss_cnt;
    logic [CNT_W-1:0]    err_cnt;
    logic                pred;
    logic                x;
    logic                mismatch;
    logic                lock_err;

    prbs_feedback #(
        .NUM_BITS (NUM_BITS),
        .TAPS     (TAPS)
    ) u_feedback (
        .r    (r),
        .pred (pred)
    );

    // While locked the register free-runs on its own prediction, so one bad
    // line bit cannot corrupt the bits predicted after it.
    assign x        = (state == LOCKED) ? pred : i_bit;
    assign mismatch = i_bit ^ pred;
    assign lock_err = i_valid && (state == LOCKED) && mismatch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= SEEK;
            r         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            good_cnt  <= '0;
            loss_cnt  <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_err <= lock_err;
            if (i_valid) begin
                r <= {r[NUM_BITS-2:0], x};
                case (state)
                    SEEK: begin
                        if (fill_cnt == FILL_LAST) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        // An all-zero register predicts 0 forever, so a line
                        // stuck at 0 would match every bit. Treat it as a
                        // failed fill and refill.
                        if (mismatch || (r == '0)) begin
                            state    <= SEEK;
                            fill_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state    <= LOCKED;
                            o_locked <= 1'b1;
                            good_cnt <= '0;
                            loss_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (mismatch) begin
                            good_cnt <= '0;
                            if (loss_cnt == LOSS_LAST) begin
                                state    <= SEEK;
                                fill_cnt <= '0;
                                o_locked <= 1'b0;
                            end else begin
                                loss_cnt <= loss_cnt + 1'b1;
                            end
                        end else if (good_cnt == MATCH_LAST) begin
                            // A full clean run forgives earlier errors.
                            good_cnt <= '0;
                            loss_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= SEEK;
                        fill_cnt <= '0;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear takes priority over an increment in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            err_cnt <= '0;
        else if (i_clr_cnt)
            err_cnt <= '0;
        else if (lock_err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

    assign o_err_cnt = err_cnt;

`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            bit_cnt <= '0;
        else if (i_clr_cnt)
            bit_cnt <= '0;
        else if (i_valid && (state == LOCKED) && (bit_cnt != '1))
            bit_cnt <= bit_cnt + 1'b1;
    end

    assign o_bit_cnt = bit_cnt;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker with the default
// parameters (5-bit LFSR, taps 5'h1B, generator seed 1).
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        i_clk     = 1'b0;
    logic        i_rst_n   = 1'b0;
    logic        i_bit     = 1'b0;
    logic        i_valid   = 1'b0;
    logic        i_clr_cnt = 1'b0;
    logic        o_locked;
    logic        o_err;
    logic [15:0] o_err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] o_bit_cnt;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [4:0] g;

    prbs_checker dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_bit     (i_bit),
        .i_valid   (i_valid),
        .i_clr_cnt (i_clr_cnt),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .o_bit_cnt (o_bit_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference generator: emits the feedback bit and shifts it in.
    task automatic gen_step(output logic b);
        b = ^(g & PRBS_TAPS);
        g = {g[3:0], b};
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step(input logic b, input logic v, input logic clr);
        i_bit     = b;
        i_valid   = v;
        i_clr_cnt = clr;
        @(posedge i_clk);
        #1;
        i_clr_cnt = 1'b0;
    endtask

    task automatic send(input logic inv);
        logic b;
        gen_step(b);
        step(b ^ inv, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        g       = PRBS_SEED;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        int lock_at, errs, nval, changes;
        logic       l0;
        logic [15:0] c0;

        // Reset state
        do_reset();
        chk("rst_locked", o_locked, 0);
        chk("rst_err", o_err, 0);
        chk("rst_err_cnt", o_err_cnt, 0);

        // 1: clean stream locks at bit 21 and stays error-free
        lock_at = 0; errs = 0;
        for (int i = 1; i <= 1000; i++) begin
            send(1'b0);
            if (o_locked && lock_at == 0) lock_at = i;
            if (o_err) errs++;
        end
        chk("t1_lock_bit", lock_at, 21);
        chk("t1_err_cnt", o_err_cnt, 0);
        chk("t1_err_pulses", errs, 0);
        chk("t1_locked", o_locked, 1);

        // 2: one flipped bit gives one error and lock is kept
        send(1'b1);
        chk("t2_err_pulse", o_err, 1);
        chk("t2_err_cnt", o_err_cnt, 1);
        chk("t2_locked", o_locked, 1);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            send(1'b0);
            if (o_err || !o_locked) errs++;
        end
        chk("t2_after_clean", errs, 0);
        chk("t2_err_cnt_kept", o_err_cnt, 1);

        // 3: clear, then four errors in ten bits drop lock; relock 21 bits later
        begin
            logic b;
            gen_step(b);
            step(b, 1'b1, 1'b1);
        end
        chk("t3_clr", o_err_cnt, 0);
        chk("t3_clr_locked", o_locked, 1);
        for (int i = 0; i < 10; i++) begin
            send(i == 0 || i == 2 || i == 5 || i == 9);
            if (i == 5) chk("t3_locked_after_3", o_locked, 1);
        end
        chk("t3_lost", o_locked, 0);
        chk("t3_err_4th", o_err, 1);
        chk("t3_err_cnt", o_err_cnt, 4);
        lock_at = 0;
        for (int i = 1; i <= 100 && lock_at == 0; i++) begin
            send(1'b0);
            if (o_locked) lock_at = i;
        end
        chk("t3_relock_bit", lock_at, 21);
        chk("t3_err_cnt_kept", o_err_cnt, 4);

        // 4: stuck-at-0 line never locks
        do_reset();
        errs = 0; lock_at = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (o_locked) lock_at++;
            if (o_err) errs++;
        end
        chk("t4_never_locked", lock_at, 0);
        chk("t4_no_err", errs, 0);

        // 5: valid every other cycle; invalid cycles carry garbage
        do_reset();
        lock_at = 0; nval = 0; changes = 0;
        for (int c = 1; c <= 200 && lock_at == 0; c++) begin
            if (c % 2 == 1) begin
                send(1'b0);
                nval++;
                if (o_locked) lock_at = nval;
            end else begin
                l0 = o_locked;
                c0 = o_err_cnt;
                step(1'($urandom_range(1)), 1'b0, 1'b0);
                if (o_locked !== l0 || o_err_cnt !== c0 || o_err !== 1'b0) changes++;
            end
        end
        chk("t5_lock_valid_bit", lock_at, 21);
        chk("t5_invalid_changes", changes, 0);
        // an error, then an invalid cycle: nothing changes and o_err is low
        send(1'b1);
        chk("t5_err_pulse", o_err, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_inv_err_low", o_err, 0);
        chk("t5_inv_cnt_hold", o_err_cnt, 1);
        chk("t5_inv_locked", o_locked, 1);

        // 6: clear coinciding with an error; then async reset mid-lock
        begin
            logic b;
            gen_step(b);
            step(~b, 1'b1, 1'b1);
        end
        chk("t6_clr_err_pulse", o_err, 1);
        chk("t6_clr_err_cnt", o_err_cnt, 0);
        chk("t6_clr_locked", o_locked, 1);
        send(1'b1);
        chk("t6_pre_rst_cnt", o_err_cnt, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_async_locked", o_locked, 0);
        chk("t6_async_err_cnt", o_err_cnt, 0);
        chk("t6_async_err", o_err, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
